muldiv_sched: RTL
=================

// Module: muldiv_sched
// PURPOSE
//  Sequencer in front of the execute-stage iterative multiply, signed-divide and unsigned-divide units.
//  Accepts one op at a time from execute, prepares operands (incl. 32-bit word ops) and launches the right unit.
//  Holds the unit's valid until data_ok, short-circuits div-by-zero/overflow, returns result+tag via valid/ready.
//  Handles pipeline flush and a stuck-unit watchdog so execute never deadlocks.
// PARAMETERS
//  TAG_W          4    width of req_tag/resp_tag (ROB/pipe slot id, opaque)
//  TIMEOUT_CYCLES 128  max cycles a unit may run before watchdog abort
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous active-high reset
//  req_valid      in   1   op request
//  req_ready      out  1   controller can accept (IDLE and !flush)
//  req_op         in   3   0 MUL,1 DIV,2 DIVU,3 REM,4 REMU; 5-7 illegal
//  req_word       in   1   32-bit (W) variant
//  req_a, req_b   in   64  operands
//  req_tag        in   TAG_W  returned unchanged
//  flush          in   1   kill in-flight / pending op
//  resp_valid     out  1   result available
//  resp_ready     in   1   consumer accepts
//  resp_data      out  64  result
//  resp_tag       out  TAG_W tag of the op
//  busy           out  1   state != IDLE
//  timeout_err    out  1   sticky; set on watchdog abort, cleared only by reset
//  unit_a, unit_b out  64  prepared operands, stable while any unit valid high
//  mul_valid, div_valid, divu_valid  out 1  unit launch/hold (at most one high)
//  mul_data_ok, div_data_ok, divu_data_ok  in 1  unit done
//  mul_result, div_quot, div_rem, divu_quot, divu_rem  in 64  unit outputs, valid with data_ok
// BEHAVIOUR
//  States: IDLE, RUN, DONE, DRAIN. Reset -> IDLE; all outputs 0; timeout_err 0; reuse entry invalid.
//  IDLE: fire = req_valid&req_ready. Illegal op -> DONE, data 0. Short-circuit -> DONE next cycle. Else RUN.
//  Operand prep (registered at fire): word&signed (MUL,DIV,REM) -> sext a[31:0],b[31:0]; word&unsigned -> zext.
//  Short-circuits (no unit launch): b==0: DIV/DIVU data all ones, REM/REMU data = prepared a.
//   64-bit DIV/REM with a==64'h8000..0, b==all ones: DIV -> a, REM -> 0.
//  RUN: selected unit valid held high; watchdog counter increments. data_ok sampled -> latch result, DONE.
//   Selected output: MUL mul_result; DIV/REM div_quot/div_rem; DIVU/REMU divu_quot/divu_rem.
//   Counter reaches TIMEOUT_CYCLES -> timeout_err<=1, result 0, -> DRAIN then DONE (resp still delivered).
//  Word result: resp_data = sext of latched [31:0]; 64-bit: unchanged.
//  Latency: short-circuit resp_valid at fire+1; unit op resp_valid one cycle after data_ok high.
//  DONE: resp_valid = !flush; data/tag stable until resp_valid&resp_ready -> IDLE (req accepted next cycle).
//  flush (any state, priority over all): unit valids 0 same cycle, -> DRAIN; no req fire, no resp fire.
//  DRAIN: one cycle, all unit valids 0 (resets iterative units), -> IDLE. Units never restart without a low cycle.
//  reset mid-op: immediate IDLE, unit valids low next cycle, pending result discarded.
// CONFIGURATION
//  MULDIV_REUSE_EN defined: one-entry cache {signed,word,a,b,quot,rem} filled on div/divu data_ok completion
//   (not on short-circuit/timeout/flush). Matching DIV/REM/DIVU/REMU at fire -> DONE next cycle, no launch.
//   Entry invalidated only by reset. Undefined: no cache, every non-short-circuit div launches the unit.
// TESTING
//  MUL a=7 b=64'hFFFF_FFFF_FFFF_FFFD, unit data_ok after 5 cyc -> mul_valid 5 cyc, resp 64'hFFFF_FFFF_FFFF_FFEB next cyc.
//  DIV a=0x1234 b=0 -> no *_valid, resp_data 64'hFFFF_FFFF_FFFF_FFFF at fire+1; REM same -> 0x1234.
//  DIV word a=0x8000_0000 b=0xFFFF_FFFF -> unit_a=64'hFFFF_FFFF_8000_0000, unit_b=-1; resp 64'hFFFF_FFFF_8000_0000.
//  DIVU running, flush on 3rd RUN cycle -> divu_valid 0 same cycle, no resp_valid, req_ready high 2 cyc after flush.
//  Unit data_ok never asserted -> after 128 cyc timeout_err=1, resp_data 0 with correct tag, then req_ready.
//  REUSE_EN: DIV 100/7 then REM 100/7 -> 2nd resp 2 at fire+1, div_valid never raised; without EN unit relaunched.

Source files
------------

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - sequencer launching the iterative mul/div units for execute
//
// Purpose: accepts one MUL/DIV/DIVU/REM/REMU request at a time, prepares
// operands (sign/zero extension for 32-bit word ops), launches and holds the
// selected unit until it reports data_ok, short-circuits divide-by-zero and
// signed overflow, aborts a stuck unit by watchdog and returns result + tag
// over a valid/ready handshake. Flush kills any in-flight or pending op.
//
// Optional feature: define MULDIV_REUSE_EN to keep a one-entry cache of the last
// completed divide so a matching DIV/REM/DIVU/REMU completes without a launch.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE without flush)
//   req_op, req_word            op code (0 MUL,1 DIV,2 DIVU,3 REM,4 REMU), 32-bit variant
//   req_a, req_b, req_tag       operands and opaque tag
//   flush                       kill in-flight / pending op
//   resp_valid/resp_ready       response handshake
//   resp_data, resp_tag         result and tag of the op
//   busy, timeout_err           not idle; sticky watchdog abort flag
//   unit_a, unit_b              prepared operands shared by all units
//   mul/div/divu_valid          unit launch/hold (one-hot or zero)
//   mul/div/divu_data_ok        unit done strobes
//   mul_result, div_*, divu_*   unit results
module muldiv_sched #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic             req_word,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy,
    output logic             timeout_err,
    output logic [63:0]      unit_a,
    output logic [63:0]      unit_b,
    output logic             mul_valid,
    output logic             div_valid,
    output logic             divu_valid,
    input  logic             mul_data_ok,
    input  logic             div_data_ok,
    input  logic             divu_data_ok,
    input  logic [63:0]      mul_result,
    input  logic [63:0]      div_quot,
    input  logic [63:0]      div_rem,
    input  logic [63:0]      divu_quot,
    input  logic [63:0]      divu_rem
);

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d;
    logic [63:0]       a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [63:0]       res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    // DRAIN normally returns to IDLE; after a watchdog abort it must still deliver a response.
    logic              drain_done_q, drain_done_d;

    // Request decode and operand preparation
    logic        req_signed, req_is_div, req_is_sdiv, req_is_rem, req_illegal;
    logic [63:0] prep_a, prep_b;
    logic        sc_zero, sc_ovf;

    always_comb begin
        req_signed  = (req_op == OP_MUL) || (req_op == OP_DIV) || (req_op == OP_REM);
        req_is_div  = (req_op >= OP_DIV) && (req_op <= OP_REMU);
        req_is_sdiv = (req_op == OP_DIV) || (req_op == OP_REM);
        req_is_rem  = (req_op == OP_REM) || (req_op == OP_REMU);
        req_illegal = (req_op > OP_REMU);
        if (req_word && req_signed) begin
            prep_a = {{32{req_a[31]}}, req_a[31:0]};
            prep_b = {{32{req_b[31]}}, req_b[31:0]};
        end else if (req_word) begin
            prep_a = {32'd0, req_a[31:0]};
            prep_b = {32'd0, req_b[31:0]};
        end else begin
            prep_a = req_a;
            prep_b = req_b;
        end
        sc_zero = req_is_div && (prep_b == 64'd0);
        // Word ops cannot overflow once extended to 64 bits, so only full-width ops short-circuit.
        sc_ovf  = req_is_sdiv && !req_word && (prep_a == INT_MIN) && (prep_b == '1);
    end

    // Selected unit's done strobe and result
    logic        unit_ok;
    logic [63:0] unit_res;

    always_comb begin
        unit_ok  = 1'b0;
        unit_res = 64'd0;
        case (op_q)
            OP_MUL:  begin unit_ok = mul_data_ok;  unit_res = mul_result; end
            OP_DIV:  begin unit_ok = div_data_ok;  unit_res = div_quot;   end
            OP_REM:  begin unit_ok = div_data_ok;  unit_res = div_rem;    end
            OP_DIVU: begin unit_ok = divu_data_ok; unit_res = divu_quot;  end
            OP_REMU: begin unit_ok = divu_data_ok; unit_res = divu_rem;   end
            default: begin unit_ok = 1'b0;         unit_res = 64'd0;      end
        endcase
    end

    logic        reuse_hit;
    logic [63:0] reuse_data;

`ifdef MULDIV_REUSE_EN
    logic        rc_valid_q, rc_signed_q, rc_word_q;
    logic [63:0] rc_a_q, rc_b_q, rc_quot_q, rc_rem_q;
    logic        rc_fill;

    // Only a genuine unit completion fills the entry; flush wins over a same-cycle data_ok.
    assign rc_fill = (state_q == S_RUN) && !flush && unit_ok && (op_q != OP_MUL);

    always_ff @(posedge clk) begin
        if (reset) begin
            rc_valid_q  <= 1'b0;
            rc_signed_q <= 1'b0;
            rc_word_q   <= 1'b0;
            rc_a_q      <= 64'd0;
            rc_b_q      <= 64'd0;
            rc_quot_q   <= 64'd0;
            rc_rem_q    <= 64'd0;
        end else if (rc_fill) begin
            rc_valid_q  <= 1'b1;
            rc_signed_q <= (op_q == OP_DIV) || (op_q == OP_REM);
            rc_word_q   <= word_q;
            rc_a_q      <= a_q;
            rc_b_q      <= b_q;
            rc_quot_q   <= (op_q == OP_DIV || op_q == OP_REM) ? div_quot : divu_quot;
            rc_rem_q    <= (op_q == OP_DIV || op_q == OP_REM) ? div_rem  : divu_rem;
        end
    end

    assign reuse_hit  = rc_valid_q && req_is_div && (rc_signed_q == req_is_sdiv) &&
                        (rc_word_q == req_word) && (rc_a_q == prep_a) && (rc_b_q == prep_b);
    assign reuse_data = req_is_rem ? rc_rem_q : rc_quot_q;
`else
    assign reuse_hit  = 1'b0;
    assign reuse_data = 64'd0;
`endif

    // Next-state and outputs
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        word_d       = word_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        drain_done_d = drain_done_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mul_valid    = 1'b0;
        div_valid    = 1'b0;
        divu_valid   = 1'b0;

        if (flush) begin
            state_d      = S_DRAIN;
            drain_done_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        op_d   = req_op;
                        word_d = req_word;
                        a_d    = prep_a;
                        b_d    = prep_b;
                        tag_d  = req_tag;
                        cnt_d  = '0;
                        if (req_illegal) begin
                            res_d   = 64'd0;
                            state_d = S_DONE;
                        end else if (sc_zero) begin
                            res_d   = req_is_rem ? prep_a : '1;
                            state_d = S_DONE;
                        end else if (sc_ovf) begin
                            res_d   = req_is_rem ? 64'd0 : prep_a;
                            state_d = S_DONE;
                        end else if (reuse_hit) begin
                            res_d   = reuse_data;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    mul_valid  = (op_q == OP_MUL);
                    div_valid  = (op_q == OP_DIV)  || (op_q == OP_REM);
                    divu_valid = (op_q == OP_DIVU) || (op_q == OP_REMU);
                    if (unit_ok) begin
                        res_d   = unit_res;
                        state_d = S_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        tmo_d        = 1'b1;
                        res_d        = 64'd0;
                        drain_done_d = 1'b1;
                        state_d      = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    resp_valid = 1'b1;
                    if (resp_ready) begin
                        state_d = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    drain_done_d = 1'b0;
                    state_d      = drain_done_q ? S_DONE : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            word_q       <= 1'b0;
            a_q          <= 64'd0;
            b_q          <= 64'd0;
            tag_q        <= '0;
            res_q        <= 64'd0;
            cnt_q        <= '0;
            tmo_q        <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            word_q       <= word_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign resp_data   = word_q ? {{32{res_q[31]}}, res_q[31:0]} : res_q;
    assign resp_tag    = tag_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = tmo_q;
    assign unit_a      = a_q;
    assign unit_b      = b_q;

endmodule
